// File: rtl/fir_decim_framer.sv
// Rounds/saturates the FIR output to OUT_WIDTH, keeps 1 of DECIM samples,
// tags FRAME_LEN-sample frames with sop/eop and queues them in a small FIFO.
module fir_decim_framer #(
   parameter int IN_WIDTH   = 28,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 12,
   parameter int DECIM      = 4,
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        fir_valid,
   input  logic signed [IN_WIDTH-1:0]  fir_data,
   input  logic                        frame_en,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic                        overflow,
   output logic [15:0]                 frame_cnt
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = OUT_WIDTH + 2;

   localparam logic signed [IN_WIDTH:0] HALF    = (IN_WIDTH+1)'(1) <<< (SHIFT-1);
   localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [IN_WIDTH:0] SAT_MIN = (IN_WIDTH+1)'(-(1 << (OUT_WIDTH-1)));

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t                      state_q;
   logic [PW-1:0]               phase_q, phase_d;
   logic [IW-1:0]               index_q;
   logic                        keep, last;
   logic signed [IN_WIDTH:0]    rnd_sum, rnd_shr;
   logic signed [OUT_WIDTH-1:0] sat;

   logic                        push_q, push_sop_q, push_eop_q;
   logic signed [OUT_WIDTH-1:0] push_data_q;

   logic [EW-1:0]               mem_q [FIFO_DEPTH];
   logic [EW-1:0]               head;
   logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [AW:0]                 count_q, count_d;
   logic                        pop, push_ok, overflow_q;
   logic [15:0]                 frame_cnt_q;

   assign keep    = (state_q == CAPTURE) && fir_valid && (phase_q == '0);
   assign last    = (index_q == IW'(FRAME_LEN-1));
   assign phase_d = (phase_q == PW'(DECIM-1)) ? '0 : phase_q + 1'b1;

   // Sign-extend by one bit so the rounding offset can never wrap.
   always_comb begin
      rnd_sum = {fir_data[IN_WIDTH-1], fir_data} + HALF;
      rnd_shr = rnd_sum >>> SHIFT;
      if (rnd_shr > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
      else if (rnd_shr < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
      else                        sat = rnd_shr[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         index_q     <= '0;
         push_q      <= 1'b0;
         push_sop_q  <= 1'b0;
         push_eop_q  <= 1'b0;
         push_data_q <= '0;
      end else begin
         push_q <= keep;
         if (keep) begin
            push_data_q <= sat;
            push_sop_q  <= (index_q == '0);
            push_eop_q  <= last;
         end
         case (state_q)
            IDLE: if (frame_en) begin
               state_q <= CAPTURE;
               phase_q <= '0;
               index_q <= '0;
            end
            CAPTURE: if (fir_valid) begin
               phase_q <= phase_d;
               if (keep) begin
                  index_q <= last ? '0 : index_q + 1'b1;
                  if (last) state_q <= IDLE;
               end
            end
         endcase
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop     = out_valid && out_ready;
   assign push_ok = push_q && ((count_q < (AW+1)'(FIFO_DEPTH)) || pop);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (!push_ok && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {push_sop_q, push_eop_q, push_data_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push_q && !push_ok)    overflow_q  <= 1'b1;
         if (push_q && push_eop_q)  frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   always_comb head = mem_q[rd_ptr_q];

   assign out_valid                   = (count_q != '0);
   assign {out_sop, out_eop, out_data} = out_valid ? head : '0;
   assign overflow                    = overflow_q;
   assign frame_cnt                   = frame_cnt_q;

endmodule

// File: tb/tb_fir_decim_framer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, per-DUT monitors pop on each handshake.
module tb_fir_decim_framer;

   typedef struct {
      int data;
      bit sop;
      bit eop;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT A: DECIM=1, short frames, rounding/saturation vectors
   logic               a_valid = 1'b0, a_en = 1'b0, a_ready = 1'b1;
   logic signed [27:0] a_data = '0;
   logic signed [15:0] a_out_data;
   logic               a_out_valid, a_out_sop, a_out_eop, a_overflow;
   logic [15:0]        a_frame_cnt;

   // DUT B: DECIM=4, FRAME_LEN=256, FIFO_DEPTH=16
   logic               b_valid = 1'b0, b_en = 1'b0, b_ready = 1'b0;
   logic signed [27:0] b_data = '0;
   logic signed [15:0] b_out_data;
   logic               b_out_valid, b_out_sop, b_out_eop, b_overflow;
   logic [15:0]        b_frame_cnt;

   fir_decim_framer #(.IN_WIDTH(28), .OUT_WIDTH(16), .SHIFT(12), .DECIM(1),
                      .FRAME_LEN(8), .FIFO_DEPTH(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .fir_valid(a_valid), .fir_data(a_data), .frame_en(a_en),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_ready),
      .out_sop(a_out_sop), .out_eop(a_out_eop), .overflow(a_overflow), .frame_cnt(a_frame_cnt));

   fir_decim_framer #(.IN_WIDTH(28), .OUT_WIDTH(16), .SHIFT(12), .DECIM(4),
                      .FRAME_LEN(256), .FIFO_DEPTH(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .fir_valid(b_valid), .fir_data(b_data), .frame_en(b_en),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_ready),
      .out_sop(b_out_sop), .out_eop(b_out_eop), .overflow(b_overflow), .frame_cnt(b_frame_cnt));

   exp_t qa[$];
   exp_t qb[$];
   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (a_out_valid && a_ready) begin
         if (qa.size() == 0) begin
            checks++;
            $display("FAIL A unexpected output: got data %0d, expected no output", a_out_data);
         end else begin
            e = qa.pop_front();
            chk("A data", int'(a_out_data), e.data);
            chk("A sop", int'(a_out_sop), int'(e.sop));
            chk("A eop", int'(a_out_eop), int'(e.eop));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (b_out_valid && b_ready) begin
         if (qb.size() == 0) begin
            checks++;
            $display("FAIL B unexpected output: got data %0d, expected no output", b_out_data);
         end else begin
            e = qb.pop_front();
            chk("B data", int'(b_out_data), e.data);
            chk("B sop", int'(b_out_sop), int'(e.sop));
            chk("B eop", int'(b_out_eop), int'(e.eop));
         end
      end
   end

   task automatic drain(input bit sel_b);
      for (int i = 0; i < 3000; i++) begin
         if (sel_b ? (qb.size() == 0 && !b_out_valid) : (qa.size() == 0 && !a_out_valid)) break;
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      if (sel_b) begin
         chk("B drain pending", qb.size(), 0);
         chk("B drain out_valid", int'(b_out_valid), 0);
      end else begin
         chk("A drain pending", qa.size(), 0);
         chk("A drain out_valid", int'(a_out_valid), 0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("B rst out_valid", int'(b_out_valid), 0);
      chk("B rst out_data", int'(b_out_data), 0);
      chk("B rst sop/eop", int'({b_out_sop, b_out_eop}), 0);
      chk("B rst overflow", int'(b_overflow), 0);
      chk("B rst frame_cnt", int'(b_frame_cnt), 0);
   endtask

   task automatic arm_b();
      b_en = 1'b1;
      @(posedge clk); #1;
   endtask

   // Ramp k*4096 rounds to exactly k; kept when k%4==0 and within the frame.
   task automatic ramp_b(input int n, input int drop_en_at, input int max_exp);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         b_valid = 1'b1;
         b_data  = 28'(k * 4096);
         if (k % 4 == 0 && k / 4 < max_exp && k <= 1020) begin
            e.data = k; e.sop = (k == 0); e.eop = (k == 1020);
            qb.push_back(e);
         end
         @(posedge clk); #1;
         if (k == drop_en_at) b_en = 1'b0;
      end
      b_valid = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int va[8];
      int ea[8];
      va = '{2048, 2047, -2048, -2049, 6144, 134217727, -134217728, 0};
      ea = '{1, 0, 0, -1, 2, 32767, -32768, 0};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("A rst out_valid", int'(a_out_valid), 0);
      chk("A rst out_data", int'(a_out_data), 0);
      chk("A rst frame_cnt", int'(a_frame_cnt), 0);
      chk("B rst0 out_valid", int'(b_out_valid), 0);
      chk("B rst0 overflow", int'(b_overflow), 0);

      // Rounding and saturation, DECIM=1, one 8-sample frame
      a_en = 1'b1;
      @(posedge clk); #1;
      a_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         e.data = ea[i]; e.sop = (i == 0); e.eop = (i == 7);
         qa.push_back(e);
         a_valid = 1'b1;
         a_data  = 28'(va[i]);
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
      drain(1'b0);
      chk("A frame_cnt", int'(a_frame_cnt), 1);
      chk("A overflow", int'(a_overflow), 0);

      // Full frame with decimation; frame_en dropped early, trailing inputs ignored
      b_ready = 1'b1;
      arm_b();
      ramp_b(1024, 0, 256);
      drain(1'b1);
      chk("B T3 frame_cnt", int'(b_frame_cnt), 1);
      chk("B T3 overflow", int'(b_overflow), 0);

      // frame_en held to kept sample 100 then dropped; no re-arm afterwards
      do_reset();
      arm_b();
      ramp_b(1100, 400, 256);
      drain(1'b1);
      chk("B T5 frame_cnt", int'(b_frame_cnt), 1);

      // Backpressure: 40 kept, only the first 16 fit
      do_reset();
      b_ready = 1'b0;
      arm_b();
      b_en = 1'b0;
      ramp_b(160, -1, 16);
      repeat (3) @(posedge clk);
      #1;
      chk("B T4 overflow", int'(b_overflow), 1);
      chk("B T4 out_valid held", int'(b_out_valid), 1);
      chk("B T4 head sop", int'(b_out_sop), 1);
      b_ready = 1'b1;
      drain(1'b1);
      chk("B T4 frame_cnt", int'(b_frame_cnt), 0);

      // Continue same frame to kept sample 50 with FIFO filling, then reset
      b_ready = 1'b0;
      for (int k = 160; k <= 200; k++) begin
         b_valid = 1'b1;
         b_data  = 28'(k * 4096);
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      @(posedge clk); #1;
      chk("B T6 fifo non-empty", int'(b_out_valid), 1);
      do_reset();
      b_ready = 1'b1;
      arm_b();
      b_en = 1'b0;
      begin
         exp_t e;
         e.data = 7; e.sop = 1'b1; e.eop = 1'b0;
         qb.push_back(e);
      end
      b_valid = 1'b1;
      b_data  = 28'(7 * 4096);
      @(posedge clk); #1;
      b_valid = 1'b0;
      drain(1'b1);
      chk("B T6 frame_cnt", int'(b_frame_cnt), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fir_decim_framer.md
Name: fir_decim_framer

Overview:
- Sits directly downstream of fir_filter in the FMCW receive chain.
- Consumes the 28-bit signed FIR output stream (fir_data/valid) and rounds and saturates it to 16 bits.
- Decimates by DECIM and groups the kept samples into chirp frames of FRAME_LEN samples.
- Delivers frames through a small FIFO with valid/ready handshake and sop/eop markers for the range-FFT stage.

Parameters:
- IN_WIDTH, 28, input sample width (fir_data).
- OUT_WIDTH, 16, output sample width.
- SHIFT, 12, arithmetic right-shift applied after rounding.
- DECIM, 4, keep 1 of every DECIM input samples (DECIM>=1).
- FRAME_LEN, 256, kept samples per frame (power of 2 not required).
- FIFO_DEPTH, 16, output FIFO entries (power of 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- fir_valid  in  1  input sample strobe (from fir_filter valid)
- fir_data  in  IN_WIDTH  signed input sample
- frame_en  in  1  arm capture of the next frame (chirp gate)
- out_data  out  OUT_WIDTH  signed output sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid=1
- out_sop  out  1  head is sample 0 of a frame
- out_eop  out  1  head is sample FRAME_LEN-1 of a frame
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full
- frame_cnt  out  16  completed frames (eop pushes), wraps at 65535->0

Behaviour:
- Reset is synchronous, active-low, on the clk edge. While rst_n=0 at an edge:
  - out_data=0, out_valid=0, out_sop=0, out_eop=0, overflow=0, frame_cnt=0.
  - FIFO emptied, state=IDLE, decimation phase=0, sample index=0.
- Reset mid-frame discards the partial frame. The first frame after reset starts with sop.
- FSM, IDLE:
  - fir_valid is ignored.
  - If frame_en=1 at the edge, go to CAPTURE with phase=0 and index=0.
- FSM, CAPTURE:
  - Each fir_valid=1 cycle advances phase: 0..DECIM-1, wrapping.
  - The sample is kept when phase==0.
  - Each kept sample advances index: 0..FRAME_LEN-1.
  - After the kept sample with index FRAME_LEN-1, return to IDLE.
  - If frame_en is still 1, IDLE re-arms on the next edge. The first fir_valid after arming is always kept.
  - Deasserting frame_en mid-frame does not truncate; the frame completes.
- Arithmetic:
  - Form a sign-extended IN_WIDTH+1 intermediate: fir_data + 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT (round half toward +inf).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Pipeline:
  - Rounding/saturation result is registered with sop/eop tags. This is the push stage.
  - FIFO write occurs one cycle after the accepted fir_valid.
  - out_valid rises the following cycle when the FIFO was empty. Input-to-out_valid latency is 2 cycles.
- FIFO:
  - Entry = {sop, eop, data}.
  - Pop when out_valid & out_ready.
  - Outputs show the head entry. Outputs hold stable while out_valid=1 and out_ready=0.
- Full handling:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set; it clears only on reset.
  - A dropped sample still advances index, so frame alignment is preserved even if its sop/eop tag is lost.
- Empty handling: a simultaneous push and pop on an empty FIFO is not possible (out_valid=0). The push lands and out_valid=1 on the next cycle.
- frame_cnt increments on the cycle the eop-tagged sample is pushed, or dropped.

Test Plan:
1. DECIM=1, frame_en=1, fir_data = 2048, 2047, -2048, -2049, 6144 -> out_data = 1, 0, 0, -1, 2 (rounded values); first carries out_sop=1.
2. Saturation: fir_data = 0x7FFFFFF, then 0x8000000 -> out_data = 32767, then -32768; overflow stays 0.
3. DECIM=4, FRAME_LEN=256, out_ready=1, ramp input k*4096 for k=0..1023 -> 256 outputs 0,4,...,1020; sop on 0, eop on 1020; frame_cnt=1.
4. Backpressure: out_ready=0 while 40 samples are kept, FIFO_DEPTH=16 -> 16 entries held, overflow=1. After out_ready=1, the first 16 kept values emerge in order with no duplicates.
5. frame_en dropped after kept sample 100 -> frame still ends with eop at index 255. Then IDLE with no further output; frame_cnt=1.
6. rst_n=0 for one edge at kept sample 50 with FIFO non-empty -> all outputs 0, frame_cnt=0, overflow=0. Next frame's first output has out_sop=1, value from the first post-arm fir_valid.
